wb_trace_buffer: RTL
====================

# wb_trace_buffer

Captures the register-file writeback stream that the processor top level exports (`ctrl_writeEnable`, `ctrl_writeReg`, `data_writeReg`, `address_imem`). Each qualifying writeback becomes a 49-bit trace entry in a FIFO, and a downstream reader drains the FIFO through a valid/ready port. A four-state arm/trigger/capture state machine decides which writebacks are recorded. Overflow is counted, never stalls the processor, and is reported as status.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of 2, minimum 2.
- `CAPT_MAX`, 256: qualifying writebacks counted in CAPTURE before the block stops on its own.
- `SKIP_R0`, 1: when 1, writes to r0 are never qualifying.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low.
- `sample_tick`  in  1  one-cycle pulse per processor cycle (a processor-clock rising edge, seen in the `clock` domain).
- `ctrl_writeEnable`  in  1  regfile write enable.
- `ctrl_writeReg`  in  5  destination register.
- `data_writeReg`  in  32  write data.
- `address_imem`  in  12  current instruction address (the tag).
- `arm`  in  1  pulse; (re)arms capture.
- `stop`  in  1  pulse; forces DONE.
- `trig_reg`  in  5  trigger register number.
- `trig_any`  in  1  1 = any qualifying write triggers.
- `out_valid`  out  1  FIFO head is valid.
- `out_ready`  in  1  reader accepts the head.
- `out_entry`  out  49  {address_imem[11:0], reg[4:0], data[31:0]}.
- `state`  out  2  IDLE=00, ARMED=01, CAPTURE=10, DONE=11.
- `fill`  out  log2(DEPTH)+1  current FIFO occupancy.
- `drop_count`  out  16  entries dropped because the FIFO was full; saturates at 0xFFFF.
- `overflow`  out  1  sticky; set by any drop.

## Operation
- A write is **qualifying** when `sample_tick & ctrl_writeEnable` is high and it is not excluded by `SKIP_R0` (`SKIP_R0` = 1 and `ctrl_writeReg` = 0).
  - Writes without `sample_tick` are ignored, so a writeback held for 4 clocks yields exactly one entry.
- State machine:
  - **IDLE**: the state after reset. No capture.
  - **ARMED**: a qualifying write with `trig_any`, or with `ctrl_writeReg == trig_reg`, moves to CAPTURE. That triggering write is pushed and counted.
  - **CAPTURE**: every qualifying write is pushed and counted. The move to DONE happens on the edge where the count reaches `CAPT_MAX`.
  - **DONE**: no capture. The block holds here until `arm`.
- `arm` in any state:
  - moves to ARMED;
  - clears the capture count, `drop_count` and `overflow`;
  - does **not** flush the FIFO.
- `stop` in ARMED or CAPTURE moves to DONE; it has no effect in IDLE or DONE. If `arm` and `stop` are high in the same cycle, `arm` wins.
- **Push**: entry = {`address_imem`, `ctrl_writeReg`, `data_writeReg`} sampled at that edge.
  - If the FIFO is full and no pop happens that cycle, the entry is dropped: `drop_count` increments (saturating) and `overflow` is set.
  - A dropped write still counts toward `CAPT_MAX`.
- **Pop**: occurs when `out_valid & out_ready`. Entries leave in strict push order.
- **Simultaneous push and pop**:
  - FIFO full: the push is accepted and `fill` is unchanged.
  - FIFO empty: only the push takes effect (there is nothing to pop).
- Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. `fill` distinguishes full (DEPTH) from empty (0).

## Timing
- Reset (asserted low, asynchronous):
  - `state`=00, `out_valid`=0, `fill`=0, `drop_count`=0, `overflow`=0, `out_entry`=0;
  - pointers and capture count are 0;
  - this applies in any state, including mid-capture and mid-readout.
- Push latency: an entry pushed at edge N is visible on `out_entry` with `out_valid`=1 right after edge N, provided the FIFO was empty.
- `out_entry` holds stable while `out_valid & ~out_ready`.
- After a pop at edge N, the next entry (if any) is presented right after edge N, so the reader can take one entry per clock.
- `state`, `fill`, `drop_count` and `overflow` are registered and update on the same edge as the event that changes them.
- The state transition caused by the trigger and the push of the triggering write happen on the same edge.

## Test plan
1. **Reset mid-capture.** Drive 5 entries in CAPTURE, then pull `reset` low between edges. Required: `state`=00, `out_valid`=0, `fill`=0, `drop_count`=0 and `overflow`=0 immediately, without waiting for a clock.
2. **Register trigger.** `trig_any`=0, `trig_reg`=5; `arm`; write r3 (0xAAAA), then r5 (0x1234, pc 0x010), then r6 (0x5678, pc 0x011). Required: `state` goes 01→10 on the r5 edge. FIFO pops exactly {0x010,5,0x1234} then {0x011,6,0x5678}; the r3 write is absent.
3. **Filtering.** With `SKIP_R0`=1, write r0: no entry. Hold an r7 write for 4 clocks with a single `sample_tick`: exactly 1 entry, `fill`=1.
4. **Overflow.** `DEPTH`=16, `out_ready`=0, 20 qualifying writes. Required: `fill`=16, `drop_count`=4, `overflow`=1. Then set `out_ready`=1: the first 16 writes pop in order, one per clock, and `out_valid`=0 afterwards.
5. **Full with simultaneous pop and push.** FIFO full, `out_ready`=1 on the same edge as a qualifying write. Required: the push is accepted, `fill` stays 16, `drop_count` is unchanged.
6. **Auto-stop, stop and arm priority.**
   - `CAPT_MAX`=4, `trig_any`=1: after the 4th write `state`=11, and a 5th write adds nothing.
   - `stop` while ARMED: `state`=11 with 0 entries.
   - `arm` and `stop` together: `state`=01.

Source files
------------

// File: rtl/wb_trace_buffer.sv
// Register-file writeback trace buffer: arm/trigger/capture FSM feeding a FIFO
// drained through a valid/ready port, with saturating overflow accounting.
module wb_trace_buffer #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned CAPT_MAX = 256,
    parameter int unsigned SKIP_R0  = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     sample_tick,
    input  logic                     ctrl_writeEnable,
    input  logic [4:0]               ctrl_writeReg,
    input  logic [31:0]              data_writeReg,
    input  logic [11:0]              address_imem,
    input  logic                     arm,
    input  logic                     stop,
    input  logic [4:0]               trig_reg,
    input  logic                     trig_any,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [48:0]              out_entry,
    output logic [1:0]               state,
    output logic [$clog2(DEPTH):0]   fill,
    output logic [15:0]              drop_count,
    output logic                     overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned FW = AW + 1;
    localparam int unsigned CW = $clog2(CAPT_MAX + 1);
    localparam int unsigned EW = 49;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ARMED   = 2'b01,
        S_CAPTURE = 2'b10,
        S_DONE    = 2'b11
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_count;
    logic [15:0]     r_drop;
    logic            r_ovf;

    logic [EW-1:0]   r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [FW-1:0]   r_fill;
    logic            r_out_valid;
    logic [EW-1:0]   r_out_entry;

    logic            w_qual;
    logic            w_trig;
    logic            w_capture;
    logic            w_full;
    logic            w_pop;
    logic            w_push_ok;
    logic            w_drop;
    logic            w_last;
    logic [EW-1:0]   w_entry;
    logic [AW-1:0]   w_rptr_nxt;
    logic [FW-1:0]   w_fill_nxt;
    logic [EW-1:0]   w_head_nxt;

    assign w_qual  = sample_tick & ctrl_writeEnable
                   & ~((SKIP_R0 != 0) && (ctrl_writeReg == 5'd0));
    assign w_trig  = w_qual & (trig_any | (ctrl_writeReg == trig_reg));
    assign w_entry = {address_imem, ctrl_writeReg, data_writeReg};

    // arm and stop both pre-empt capture on the cycle they are asserted
    assign w_capture = ~arm & ~stop
                     & (((r_state == S_ARMED) & w_trig) | ((r_state == S_CAPTURE) & w_qual));
    assign w_last    = (r_count + CW'(1)) == CW'(CAPT_MAX);

    assign w_full     = (r_fill == FW'(DEPTH));
    assign w_pop      = r_out_valid & out_ready;
    assign w_push_ok  = w_capture & (~w_full | w_pop);
    assign w_drop     = w_capture & w_full & ~w_pop;
    assign w_rptr_nxt = w_pop ? (r_rptr + AW'(1)) : r_rptr;
    assign w_fill_nxt = r_fill + FW'(w_push_ok) - FW'(w_pop);

    // Next head: bypass the incoming entry when it lands exactly at the new read slot
    always_comb begin
        w_head_nxt = '0;
        if (w_fill_nxt != '0) begin
            if (w_push_ok && (w_rptr_nxt == r_wptr)) begin
                w_head_nxt = w_entry;
            end else begin
                w_head_nxt = r_mem[w_rptr_nxt];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_drop  <= '0;
            r_ovf   <= 1'b0;
        end else if (arm) begin
            r_state <= S_ARMED;
            r_count <= '0;
            r_drop  <= '0;
            r_ovf   <= 1'b0;
        end else if (stop && ((r_state == S_ARMED) || (r_state == S_CAPTURE))) begin
            r_state <= S_DONE;
        end else if (w_capture) begin
            r_count <= r_count + CW'(1);
            r_state <= w_last ? S_DONE : S_CAPTURE;
            if (w_drop) begin
                r_ovf <= 1'b1;
                if (r_drop != 16'hFFFF) begin
                    r_drop <= r_drop + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= w_entry;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_fill      <= '0;
            r_out_valid <= 1'b0;
            r_out_entry <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + AW'(1);
            end
            r_rptr      <= w_rptr_nxt;
            r_fill      <= w_fill_nxt;
            r_out_valid <= (w_fill_nxt != '0);
            r_out_entry <= w_head_nxt;
        end
    end

    assign state      = r_state;
    assign fill       = r_fill;
    assign drop_count = r_drop;
    assign overflow   = r_ovf;
    assign out_valid  = r_out_valid;
    assign out_entry  = r_out_entry;

endmodule
